// File: rtl/rv_decode_pkg.sv
// Shared decode types for the RV32I/RV64I decode stage: format codes, opcodes and the decoded-field record.
package rv_decode_pkg;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_INV = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_IMM_32   = 7'b0011011;
  localparam logic [6:0] OP_32       = 7'b0111011;

  // Everything except PC and immediate, whose widths depend on parameters.
  typedef struct packed {
    fmt_e       fmt;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [6:0] opcode;
    logic       illegal;
  } dec_fields_t;

  localparam int DEC_W = $bits(dec_fields_t);

endpackage

// File: rtl/rv_decode_if.sv
// Fetch-side and issue-side handshake bundle of the decode stage.
interface rv_decode_if #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [2:0]      out_fmt;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [6:0]      out_opcode;
  logic [XLEN-1:0] out_imm;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_fmt, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_opcode, out_imm, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_fmt, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_opcode, out_imm, out_illegal
  );
endinterface

// File: rtl/rv_decode_comb.sv
// Purely combinational RV32I/RV64I instruction decoder: format, fields, immediate, illegal flag.
module rv_decode_comb
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output dec_fields_t     fields_o,
  output logic [XLEN-1:0] imm_o
);

  logic [6:0]  opcode;
  logic [31:0] imm32;
  fmt_e        fmt;

  assign opcode = instr_i[6:0];

  always_comb begin
    fmt = FMT_INV;
    case (opcode)
      OP_OP:                                          fmt = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_MISC_MEM: fmt = FMT_I;
      OP_STORE:                                       fmt = FMT_S;
      OP_BRANCH:                                      fmt = FMT_B;
      OP_LUI, OP_AUIPC:                               fmt = FMT_U;
      OP_JAL:                                         fmt = FMT_J;
      OP_IMM_32: if (XLEN == 64) fmt = FMT_I;
      OP_32:     if (XLEN == 64) fmt = FMT_R;
      default:                                        fmt = FMT_INV;
    endcase
    if (instr_i[1:0] != 2'b11) fmt = FMT_INV;
  end

  always_comb begin
    fields_o        = '0;
    fields_o.fmt    = fmt;
    fields_o.opcode = opcode;
    imm32           = '0;
    case (fmt)
      FMT_R: begin
        fields_o.rd     = instr_i[11:7];
        fields_o.rs1    = instr_i[19:15];
        fields_o.rs2    = instr_i[24:20];
        fields_o.funct3 = instr_i[14:12];
        fields_o.funct7 = instr_i[31:25];
      end
      FMT_I: begin
        fields_o.rd     = instr_i[11:7];
        fields_o.rs1    = instr_i[19:15];
        fields_o.funct3 = instr_i[14:12];
        // Only the immediate shifts carry a meaningful funct7.
        if (opcode == OP_IMM && (instr_i[14:12] == 3'b001 || instr_i[14:12] == 3'b101))
          fields_o.funct7 = instr_i[31:25];
        imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      FMT_S: begin
        fields_o.rs1    = instr_i[19:15];
        fields_o.rs2    = instr_i[24:20];
        fields_o.funct3 = instr_i[14:12];
        imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      end
      FMT_B: begin
        fields_o.rs1    = instr_i[19:15];
        fields_o.rs2    = instr_i[24:20];
        fields_o.funct3 = instr_i[14:12];
        imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      end
      FMT_U: begin
        fields_o.rd = instr_i[11:7];
        imm32 = {instr_i[31:12], 12'b0};
      end
      FMT_J: begin
        fields_o.rd = instr_i[11:7];
        imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      end
      default: fields_o.illegal = 1'b1;
    endcase
  end

  assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/rv_decode_stage.sv
// Registered decode stage with a DEPTH-entry output queue and flush.
// Optional RV_DECODE_PERF_EN adds saturating perf_decoded / perf_illegal counters.
module rv_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  rv_decode_if.slave  bus
`ifdef RV_DECODE_PERF_EN
  ,
  output logic [31:0] perf_decoded,
  output logic [31:0] perf_illegal
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [XLEN-1:0] imm;
    dec_fields_t     f;
  } entry_t;

  dec_fields_t     dec_f;
  logic [XLEN-1:0] dec_imm;
  entry_t          new_entry;
  entry_t          head;
  entry_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic push, pop;

  rv_decode_comb #(.XLEN(XLEN)) u_comb (
    .instr_i  (bus.in_instr),
    .fields_o (dec_f),
    .imm_o    (dec_imm)
  );

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign bus.in_ready  = (count_q < CNT_W'(DEPTH));
  assign bus.out_valid = (count_q != '0);
  assign push = bus.in_valid & bus.in_ready & ~flush;
  assign pop  = bus.out_valid & bus.out_ready & ~flush;

  assign new_entry = '{pc: bus.in_pc, imm: dec_imm, f: dec_f};

  always_comb begin
    count_d = count_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (flush) begin
      count_d = '0;
      wr_d    = '0;
      rd_d    = '0;
    end else begin
      if (push) wr_d = ptr_inc(wr_q);
      if (pop)  rd_d = ptr_inc(rd_q);
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      if (push) mem_q[wr_q] <= new_entry;
    end
  end

  // Fields read as zero whenever the queue is empty, so reset needs no extra clearing.
  assign head = bus.out_valid ? mem_q[rd_q] : '0;

  assign bus.out_pc      = head.pc;
  assign bus.out_imm     = head.imm;
  assign bus.out_fmt     = head.f.fmt;
  assign bus.out_rd      = head.f.rd;
  assign bus.out_rs1     = head.f.rs1;
  assign bus.out_rs2     = head.f.rs2;
  assign bus.out_funct3  = head.f.funct3;
  assign bus.out_funct7  = head.f.funct7;
  assign bus.out_opcode  = head.f.opcode;
  assign bus.out_illegal = head.f.illegal;

`ifdef RV_DECODE_PERF_EN
  logic [31:0] perf_dec_q, perf_ill_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_dec_q <= '0;
      perf_ill_q <= '0;
    end else begin
      if (push && perf_dec_q != '1) perf_dec_q <= perf_dec_q + 1'b1;
      if (push && dec_f.illegal && perf_ill_q != '1) perf_ill_q <= perf_ill_q + 1'b1;
    end
  end

  assign perf_decoded = perf_dec_q;
  assign perf_illegal = perf_ill_q;
`endif

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed self-checking bench for rv_decode_stage: RV32 and RV64 instances, backpressure, flush, reset.
`timescale 1ns/1ps
module tb_rv_decode_stage;
  import rv_decode_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush32 = 1'b0;
  logic flush64 = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  rv_decode_if #(.XLEN(32), .PC_W(32)) b32 ();
  rv_decode_if #(.XLEN(64), .PC_W(32)) b64 ();

  rv_decode_stage #(.XLEN(32), .PC_W(32), .DEPTH(2)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush32), .bus(b32)
  );
  rv_decode_stage #(.XLEN(64), .PC_W(32), .DEPTH(2)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush64), .bus(b64)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_in(input bit w64, input logic v, input logic [31:0] ins, input logic [31:0] pc);
    if (w64) begin b64.in_valid = v; b64.in_instr = ins; b64.in_pc = pc; end
    else     begin b32.in_valid = v; b32.in_instr = ins; b32.in_pc = pc; end
  endtask

  // One accepted instruction into an empty queue; it must be at the head one cycle later.
  task automatic send(input bit w64, input string tag, input logic [31:0] ins, input logic [31:0] pc);
    @(negedge clk);
    drive_in(w64, 1'b1, ins, pc);
    @(negedge clk);
    drive_in(w64, 1'b0, '0, '0);
    check({tag, ".valid"}, 64'(w64 ? b64.out_valid : b32.out_valid), 64'd1);
    check({tag, ".pc"}, 64'(w64 ? b64.out_pc : b32.out_pc), 64'(pc));
  endtask

  task automatic pop(input bit w64);
    if (w64) b64.out_ready = 1'b1; else b32.out_ready = 1'b1;
    @(negedge clk);
    if (w64) b64.out_ready = 1'b0; else b32.out_ready = 1'b0;
  endtask

  task automatic chk_entry(input bit w64, input string tag, input logic [2:0] fmt,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [2:0] f3, input logic [6:0] f7, input logic [6:0] opc,
                           input logic [63:0] imm, input logic ill);
    check({tag, ".fmt"}, 64'(w64 ? b64.out_fmt : b32.out_fmt), 64'(fmt));
    check({tag, ".rd"},  64'(w64 ? b64.out_rd  : b32.out_rd),  64'(rd));
    check({tag, ".rs1"}, 64'(w64 ? b64.out_rs1 : b32.out_rs1), 64'(rs1));
    check({tag, ".rs2"}, 64'(w64 ? b64.out_rs2 : b32.out_rs2), 64'(rs2));
    check({tag, ".f3"},  64'(w64 ? b64.out_funct3 : b32.out_funct3), 64'(f3));
    check({tag, ".f7"},  64'(w64 ? b64.out_funct7 : b32.out_funct7), 64'(f7));
    check({tag, ".opc"}, 64'(w64 ? b64.out_opcode : b32.out_opcode), 64'(opc));
    check({tag, ".imm"}, w64 ? b64.out_imm : {32'b0, b32.out_imm}, imm);
    check({tag, ".ill"}, 64'(w64 ? b64.out_illegal : b32.out_illegal), 64'(ill));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    b32.in_valid = 0; b32.in_instr = '0; b32.in_pc = '0; b32.out_ready = 0;
    b64.in_valid = 0; b64.in_instr = '0; b64.in_pc = '0; b64.out_ready = 0;
    #12;
    check("rst.valid", 64'(b32.out_valid), 64'd0);
    check("rst.ready", 64'(b32.in_ready), 64'd1);
    check("rst.imm",   64'(b32.out_imm), 64'd0);
    check("rst.pc",    64'(b32.out_pc), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // RV32 single-instruction vectors
    send(0, "addi", 32'hFFF10093, 32'h100);
    chk_entry(0, "addi", FMT_I, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 7'h13, 64'hFFFF_FFFF, 1'b0);
    pop(0);
    check("addi.drained", 64'(b32.out_valid), 64'd0);
    send(0, "sw", 32'h00512423, 32'h104);
    chk_entry(0, "sw", FMT_S, 5'd0, 5'd2, 5'd5, 3'd2, 7'h00, 7'h23, 64'h8, 1'b0);
    pop(0);
    send(0, "beq", 32'hFE000EE3, 32'h108);
    chk_entry(0, "beq", FMT_B, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 7'h63, 64'hFFFF_FFFC, 1'b0);
    pop(0);
    send(0, "jal", 32'h001000EF, 32'h10C);
    chk_entry(0, "jal", FMT_J, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 7'h6F, 64'h800, 1'b0);
    pop(0);
    send(0, "sub", 32'h402081B3, 32'h110);
    chk_entry(0, "sub", FMT_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 7'h33, 64'h0, 1'b0);
    pop(0);
    send(0, "srai", 32'h40335293, 32'h114);
    chk_entry(0, "srai", FMT_I, 5'd5, 5'd6, 5'd0, 3'd5, 7'h20, 7'h13, 64'h403, 1'b0);
    pop(0);
    send(0, "lui32", 32'h80000037, 32'h118);
    chk_entry(0, "lui32", FMT_U, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 7'h37, 64'h8000_0000, 1'b0);
    pop(0);
    send(0, "zero", 32'h00000000, 32'h11C);
    chk_entry(0, "zero", FMT_INV, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 7'h00, 64'h0, 1'b1);
    pop(0);
    send(0, "addiw32", 32'h0000051B, 32'h120);
    chk_entry(0, "addiw32", FMT_INV, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 7'h1B, 64'h0, 1'b1);
    pop(0);

    // RV64 vectors
    send(1, "lui64", 32'h123451B7, 32'h400);
    chk_entry(1, "lui64", FMT_U, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 7'h37, 64'h0000_0000_1234_5000, 1'b0);
    pop(1);
    send(1, "lui64n", 32'h80000037, 32'h404);
    chk_entry(1, "lui64n", FMT_U, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 7'h37, 64'hFFFF_FFFF_8000_0000, 1'b0);
    pop(1);
    send(1, "addiw64", 32'h0000051B, 32'h408);
    chk_entry(1, "addiw64", FMT_I, 5'd10, 5'd0, 5'd0, 3'd0, 7'h00, 7'h1B, 64'h0, 1'b0);
    pop(1);
    send(1, "addi64", 32'hFFF10093, 32'h40C);
    check("addi64.imm", b64.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    pop(1);

    // Backpressure: three back-to-back inputs with the consumer stalled
    @(negedge clk);
    drive_in(0, 1'b1, 32'hFFF10093, 32'h200);
    @(negedge clk);
    check("bp.rdy1", 64'(b32.in_ready), 64'd1);
    drive_in(0, 1'b1, 32'h00512423, 32'h204);
    @(negedge clk);
    check("bp.full", 64'(b32.in_ready), 64'd0);
    check("bp.head0", 64'(b32.out_pc), 64'h200);
    drive_in(0, 1'b1, 32'h001000EF, 32'h208);
    b32.out_ready = 1'b1;
    #1;
    check("bp.full_or", 64'(b32.in_ready), 64'd0);
    @(negedge clk);
    check("bp.head1", 64'(b32.out_pc), 64'h204);
    check("bp.head1.fmt", 64'(b32.out_fmt), 64'(FMT_S));
    check("bp.rdy2", 64'(b32.in_ready), 64'd1);
    @(negedge clk);
    check("bp.head2", 64'(b32.out_pc), 64'h208);
    check("bp.head2.fmt", 64'(b32.out_fmt), 64'(FMT_J));
    drive_in(0, 1'b0, '0, '0);
    @(negedge clk);
    check("bp.empty", 64'(b32.out_valid), 64'd0);
    b32.out_ready = 1'b0;

    // Flush with two entries queued, an input and a pop attempt in the same cycle
    @(negedge clk);
    drive_in(0, 1'b1, 32'hFFF10093, 32'h300);
    @(negedge clk);
    drive_in(0, 1'b1, 32'h00512423, 32'h304);
    @(negedge clk);
    check("fl.pre", 64'(b32.out_valid), 64'd1);
    flush32 = 1'b1;
    b32.out_ready = 1'b1;
    @(negedge clk);
    flush32 = 1'b0;
    b32.out_ready = 1'b0;
    drive_in(0, 1'b0, '0, '0);
    check("fl.valid", 64'(b32.out_valid), 64'd0);
    check("fl.ready", 64'(b32.in_ready), 64'd1);
    // Flush with one queued and a live input: the input must be dropped too
    send(0, "fl2.push", 32'h002081B3, 32'h310);
    drive_in(0, 1'b1, 32'h001000EF, 32'h314);
    flush32 = 1'b1;
    @(negedge clk);
    flush32 = 1'b0;
    drive_in(0, 1'b0, '0, '0);
    check("fl2.valid", 64'(b32.out_valid), 64'd0);
    @(negedge clk);
    check("fl2.drop", 64'(b32.out_valid), 64'd0);

    // Asynchronous reset mid-stream
    send(0, "rs.push", 32'h00512423, 32'h500);
    #2 rst_n = 1'b0;
    #1;
    check("rs.valid", 64'(b32.out_valid), 64'd0);
    check("rs.ready", 64'(b32.in_ready), 64'd1);
    check("rs.pc", 64'(b32.out_pc), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(0, "post", 32'h001000EF, 32'h600);
    chk_entry(0, "post", FMT_J, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 7'h6F, 64'h800, 1'b0);
    pop(0);
    check("post.empty", 64'(b32.out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
